// File: rtl/wb_stage_if.sv
// Bundle between the memory stage, the writeback stage and the register file write port.
// Handshake: an instruction transfers on a rising clk edge where in_valid && in_ready; in_valid may rise at any time, and in_ready depends only on stage state and reset.
interface wb_stage_if #(
  parameter int CNT_W = 64
);
  logic             in_valid;
  logic             in_ready;
  logic             in_reg_write;
  logic [4:0]       in_rd;
  logic [1:0]       in_result_src;
  logic [31:0]      in_alu_result;
  logic [31:0]      in_pc_plus4;
  logic [2:0]       in_funct3;
  logic [1:0]       in_addr_lo;
  logic             mem_rvalid;
  logic [31:0]      mem_rdata;
  logic             we3;
  logic [4:0]       a3;
  logic [31:0]      wd3;
  logic             wb_err;
  logic [CNT_W-1:0] instret;
  logic             state_dbg;

  modport master (
    output in_valid, in_reg_write, in_rd, in_result_src, in_alu_result,
           in_pc_plus4, in_funct3, in_addr_lo, mem_rvalid, mem_rdata,
    input  in_ready, we3, a3, wd3, wb_err, instret, state_dbg
  );

  modport slave (
    input  in_valid, in_reg_write, in_rd, in_result_src, in_alu_result,
           in_pc_plus4, in_funct3, in_addr_lo, mem_rvalid, mem_rdata,
    output in_ready, we3, a3, wd3, wb_err, instret, state_dbg
  );
endinterface

// File: rtl/wb_stage.sv
// RV writeback stage: picks ALU / PC+4 / formatted load data for the register file
// write port, stalls on outstanding loads and counts retired instructions.
module wb_stage #(
  parameter int CNT_W = 64
) (
  input  logic      clk,
  input  logic      rst_n,
  wb_stage_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, WAIT_LOAD = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_we3, w_we3_nxt;
  logic [4:0]       r_a3, w_a3_nxt;
  logic [31:0]      r_wd3, w_wd3_nxt;
  logic             r_err, w_err_nxt;
  logic [CNT_W-1:0] r_instret;
  logic             w_inc, w_cap;

  logic [4:0]       r_ld_rd;
  logic             r_ld_reg_write;
  logic [2:0]       r_ld_funct3;
  logic [1:0]       r_ld_addr_lo;

  logic             w_accept, w_wen_in, w_wen_ld;
  logic             w_bad_f3, w_misalign, w_illegal;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_ld_data;

  assign bus.in_ready  = (r_state == IDLE) && rst_n;
  assign bus.we3       = r_we3;
  assign bus.a3        = r_a3;
  assign bus.wd3       = r_wd3;
  assign bus.wb_err    = r_err;
  assign bus.instret   = r_instret;
  assign bus.state_dbg = (r_state == WAIT_LOAD);

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_wen_in = bus.in_reg_write && (bus.in_rd != 5'd0);
  assign w_wen_ld = r_ld_reg_write && (r_ld_rd != 5'd0);

  // Load-type legality and alignment only matter for load instructions.
  assign w_bad_f3   = (bus.in_funct3 == 3'b011) || (bus.in_funct3 == 3'b110) ||
                      (bus.in_funct3 == 3'b111);
  assign w_misalign = (((bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101)) &&
                       bus.in_addr_lo[0]) ||
                      ((bus.in_funct3 == 3'b010) && (bus.in_addr_lo != 2'b00));
  assign w_illegal  = (bus.in_result_src == 2'b11) ||
                      ((bus.in_result_src == 2'b01) && (w_bad_f3 || w_misalign));

  always_comb begin
    w_byte = bus.mem_rdata[7:0];
    case (r_ld_addr_lo)
      2'd1:    w_byte = bus.mem_rdata[15:8];
      2'd2:    w_byte = bus.mem_rdata[23:16];
      2'd3:    w_byte = bus.mem_rdata[31:24];
      default: w_byte = bus.mem_rdata[7:0];
    endcase
    w_half = r_ld_addr_lo[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (r_ld_funct3)
      3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ld_data = {24'd0, w_byte};
      3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_ld_data = {16'd0, w_half};
      default: w_ld_data = bus.mem_rdata;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we3_nxt   = 1'b0;
    w_a3_nxt    = r_a3;
    w_wd3_nxt   = r_wd3;
    w_err_nxt   = 1'b0;
    w_inc       = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_illegal) begin
            w_err_nxt = 1'b1;
          end else if (bus.in_result_src == 2'b01) begin
            w_state_nxt = WAIT_LOAD;
            w_cap       = 1'b1;
          end else begin
            w_we3_nxt = w_wen_in;
            w_a3_nxt  = bus.in_rd;
            w_wd3_nxt = (bus.in_result_src == 2'b10) ? bus.in_pc_plus4 : bus.in_alu_result;
            w_inc     = 1'b1;
          end
        end
      end
      WAIT_LOAD: begin
        if (bus.mem_rvalid) begin
          w_state_nxt = IDLE;
          w_we3_nxt   = w_wen_ld;
          w_a3_nxt    = r_ld_rd;
          w_wd3_nxt   = w_ld_data;
          w_inc       = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_we3          <= 1'b0;
      r_a3           <= 5'd0;
      r_wd3          <= 32'd0;
      r_err          <= 1'b0;
      r_instret      <= '0;
      r_ld_rd        <= 5'd0;
      r_ld_reg_write <= 1'b0;
      r_ld_funct3    <= 3'd0;
      r_ld_addr_lo   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_we3   <= w_we3_nxt;
      r_a3    <= w_a3_nxt;
      r_wd3   <= w_wd3_nxt;
      r_err   <= w_err_nxt;
      if (w_inc) r_instret <= r_instret + CNT_W'(1);
      if (w_cap) begin
        r_ld_rd        <= bus.in_rd;
        r_ld_reg_write <= bus.in_reg_write;
        r_ld_funct3    <= bus.in_funct3;
        r_ld_addr_lo   <= bus.in_addr_lo;
      end
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: table of single-instruction vectors, directed multi-cycle
// sequences, a random ALU burst and a narrow-counter wrap instance.
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_stage_if #(.CNT_W(64)) bus();
  wb_stage_if #(.CNT_W(4))  bus4();

  wb_stage #(.CNT_W(64)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  wb_stage #(.CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  typedef struct {
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] rdata;
    int          lat;
    logic        err;
    logic [31:0] exp_wd;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs[NVEC];

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_instret = 64'd0;
  // {wb_err, we3, a3, wd3}
  logic [38:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every write or error pulse is matched to the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (bus.we3 === 1'b1 || bus.wb_err === 1'b1) begin
      logic [38:0] act, exp;
      act = bus.wb_err ? {1'b1, bus.we3, 5'd0, 32'd0} : {1'b0, bus.we3, bus.a3, bus.wd3};
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_event", {25'd0, act}, 64'd0);
      end else begin
        exp = exp_q.pop_front();
        chk("sb_event", {25'd0, act}, {25'd0, exp});
      end
    end
  end

  task automatic drive_instr(input logic [1:0] src, input logic [2:0] f3, input logic [1:0] off,
                             input logic [4:0] rd, input logic rw, input logic [31:0] alu,
                             input logic [31:0] pc4);
    bus.in_valid      = 1'b1;
    bus.in_result_src = src;
    bus.in_funct3     = f3;
    bus.in_addr_lo    = off;
    bus.in_rd         = rd;
    bus.in_reg_write  = rw;
    bus.in_alu_result = alu;
    bus.in_pc_plus4   = pc4;
  endtask

  task automatic apply_vec(input vec_t v);
    int   wait_n;
    logic exp_we;
    wait_n = 0;
    while (bus.in_ready !== 1'b1 && wait_n < 20) begin
      @(posedge clk); #1;
      wait_n++;
    end
    chk("ready_before_accept", {63'd0, bus.in_ready}, 64'd1);
    exp_we = v.rw && (v.rd != 5'd0) && !v.err;
    drive_instr(v.src, v.f3, v.off, v.rd, v.rw, v.alu, v.pc4);
    if (v.err) exp_q.push_back({1'b1, 1'b0, 5'd0, 32'd0});
    else if (exp_we) exp_q.push_back({1'b0, 1'b1, v.rd, v.exp_wd});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (v.src == 2'b01 && !v.err) begin
      for (int k = 1; k < v.lat; k++) begin
        chk("load_wait_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("load_wait_we3", {63'd0, bus.we3}, 64'd0);
        @(posedge clk); #1;
      end
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = v.rdata;
      chk("load_rvalid_ready", {63'd0, bus.in_ready}, 64'd0);
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
    end
    if (!v.err) exp_instret++;
    chk("we3", {63'd0, bus.we3}, {63'd0, exp_we});
    chk("wb_err", {63'd0, bus.wb_err}, {63'd0, v.err});
    chk("instret", bus.instret, exp_instret);
    if (!v.err) begin
      chk("a3", {59'd0, bus.a3}, {59'd0, v.rd});
      chk("wd3", {32'd0, bus.wd3}, {32'd0, v.exp_wd});
    end
    chk("ready_after", {63'd0, bus.in_ready}, 64'd1);
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL global_timeout at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vecs[0]  = '{2'b00, 3'b010, 2'd0, 5'd5,  1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 0, 1'b0, 32'hDEADBEEF};
    vecs[1]  = '{2'b00, 3'b010, 2'd0, 5'd0,  1'b1, 32'h12345678, 32'h0, 32'h0, 0, 1'b0, 32'h12345678};
    vecs[2]  = '{2'b10, 3'b010, 2'd0, 5'd1,  1'b1, 32'h0000AAAA, 32'h00001004, 32'h0, 0, 1'b0, 32'h00001004};
    vecs[3]  = '{2'b01, 3'b000, 2'd3, 5'd10, 1'b1, 32'h0, 32'h0, 32'h80F17F82, 3, 1'b0, 32'hFFFFFF80};
    vecs[4]  = '{2'b01, 3'b100, 2'd1, 5'd11, 1'b1, 32'h0, 32'h0, 32'h80F17F82, 3, 1'b0, 32'h0000007F};
    vecs[5]  = '{2'b01, 3'b001, 2'd2, 5'd12, 1'b1, 32'h0, 32'h0, 32'h80F17F82, 3, 1'b0, 32'hFFFF80F1};
    vecs[6]  = '{2'b01, 3'b101, 2'd0, 5'd13, 1'b1, 32'h0, 32'h0, 32'h80F17F82, 3, 1'b0, 32'h00007F82};
    vecs[7]  = '{2'b01, 3'b010, 2'd0, 5'd14, 1'b1, 32'h0, 32'h0, 32'h80F17F82, 3, 1'b0, 32'h80F17F82};
    vecs[8]  = '{2'b01, 3'b010, 2'd2, 5'd20, 1'b1, 32'h0, 32'h0, 32'h0, 0, 1'b1, 32'h0};
    vecs[9]  = '{2'b01, 3'b110, 2'd0, 5'd20, 1'b1, 32'h0, 32'h0, 32'h0, 0, 1'b1, 32'h0};
    vecs[10] = '{2'b11, 3'b010, 2'd0, 5'd20, 1'b1, 32'h0, 32'h0, 32'h0, 0, 1'b1, 32'h0};
    vecs[11] = '{2'b01, 3'b000, 2'd0, 5'd15, 1'b0, 32'h0, 32'h0, 32'h12345682, 1, 1'b0, 32'hFFFFFF82};
    vecs[12] = '{2'b01, 3'b001, 2'd1, 5'd21, 1'b1, 32'h0, 32'h0, 32'h0, 0, 1'b1, 32'h0};
    vecs[13] = '{2'b01, 3'b100, 2'd2, 5'd31, 1'b1, 32'h0, 32'h0, 32'h00AB0000, 1, 1'b0, 32'h000000AB};

    rst_n = 1'b0;
    drive_instr(2'b00, 3'b010, 2'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    bus.in_valid    = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = 32'd0;
    bus4.in_valid      = 1'b0;
    bus4.in_reg_write  = 1'b0;
    bus4.in_rd         = 5'd0;
    bus4.in_result_src = 2'b00;
    bus4.in_alu_result = 32'd0;
    bus4.in_pc_plus4   = 32'd0;
    bus4.in_funct3     = 3'b010;
    bus4.in_addr_lo    = 2'd0;
    bus4.mem_rvalid    = 1'b0;
    bus4.mem_rdata     = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_low", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_we3", {63'd0, bus.we3}, 64'd0);
    chk("rst_a3", {59'd0, bus.a3}, 64'd0);
    chk("rst_wd3", {32'd0, bus.wd3}, 64'd0);
    chk("rst_wb_err", {63'd0, bus.wb_err}, 64'd0);
    chk("rst_instret", bus.instret, 64'd0);
    chk("rst_state", {63'd0, bus.state_dbg}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready", {63'd0, bus.in_ready}, 64'd1);

    for (int i = 0; i < NVEC; i++) apply_vec(vecs[i]);

    // Back-to-back ALU writes, one per cycle.
    for (int i = 0; i < 3; i++) begin
      chk("b2b_ready", {63'd0, bus.in_ready}, 64'd1);
      drive_instr(2'b00, 3'b010, 2'd0, 5'(i + 1), 1'b1, 32'h100 + 32'(i), 32'd0);
      exp_q.push_back({1'b0, 1'b1, 5'(i + 1), 32'h100 + 32'(i)});
      exp_instret++;
      @(posedge clk); #1;
      chk("b2b_we3", {63'd0, bus.we3}, 64'd1);
      chk("b2b_a3", {59'd0, bus.a3}, 64'(i + 1));
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_we3_drop", {63'd0, bus.we3}, 64'd0);
    chk("b2b_hold_a3", {59'd0, bus.a3}, 64'd3);
    chk("b2b_instret", bus.instret, exp_instret);

    // Random ALU / PC+4 burst with occasional bubbles.
    for (int i = 0; i < 24; i++) begin
      logic [4:0]  rd;
      logic        rw;
      logic [1:0]  src;
      logic [31:0] alu, pc4;
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      rd  = 5'($urandom_range(0, 31));
      rw  = 1'($urandom_range(0, 1));
      src = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
      alu = $urandom;
      pc4 = $urandom;
      drive_instr(src, 3'b010, 2'd0, rd, rw, alu, pc4);
      if (rw && rd != 5'd0) exp_q.push_back({1'b0, 1'b1, rd, (src == 2'b10) ? pc4 : alu});
      exp_instret++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rand_instret", bus.instret, exp_instret);

    // Stray response with nothing outstanding.
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h55AA55AA;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    chk("stray_we3", {63'd0, bus.we3}, 64'd0);
    chk("stray_err", {63'd0, bus.wb_err}, 64'd0);
    chk("stray_instret", bus.instret, exp_instret);

    // Reset while a load is outstanding; the late response must be dropped.
    drive_instr(2'b01, 3'b010, 2'd0, 5'd7, 1'b1, 32'd0, 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("rstld_waiting", {63'd0, bus.state_dbg}, 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_instret = 64'd0;
    #1;
    chk("rstld_state", {63'd0, bus.state_dbg}, 64'd0);
    chk("rstld_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rstld_instret", bus.instret, 64'd0);
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    chk("rstld_no_write", {63'd0, bus.we3}, 64'd0);
    chk("rstld_a3", {59'd0, bus.a3}, 64'd0);
    chk("rstld_instret_after", bus.instret, 64'd0);

    // Narrow counter wraps modulo 16.
    bus4.in_valid = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk); #1;
      if (i == 15) chk("wrap_15", {60'd0, bus4.instret}, 64'd15);
      if (i == 16) chk("wrap_16", {60'd0, bus4.instret}, 64'd0);
    end
    bus4.in_valid = 1'b0;
    chk("wrap_17", {60'd0, bus4.instret}, 64'd1);

    @(posedge clk); #1;
    chk("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
